glyph_loader: RTL and testbench

Sequencer that loads character glyphs into the 2048x8 bitmap RAM through its write port (write_data/write_addr/write_strobe).
- LOAD command: takes a 7-bit character code, then streams 16 row bytes over a valid/ready handshake.
- FILL command: writes one constant byte to all 16 rows of a character.
- Writes are gated by a display-blanking window, so glyph updates never collide with active video reads.
- Sits between the CPU-side command interface and bitmap RAM in the text-mode VGA path.

---
 rtl/glyph_loader.sv | 149 ++++++++++++++
 tb/tb_glyph_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_loader.sv
// glyph_loader: sequences LOAD / FILL commands into the 2048x8 glyph bitmap RAM.
// Each command writes 16 rows at address {char, row}, rows 0..15 in order.
// Writes only go out while the blanking window is open, so they cannot collide
// with active video reads. The write port outputs are registered and lag the
// handshake by one cycle.
module glyph_loader #(
  parameter bit USE_WINDOW = 1'b1,
  parameter int ROWS_LOG2  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [6:0]  cmd_char,
  input  logic [7:0]  cmd_fill,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic        data_ready,
  input  logic        window,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [7:0]  glyph_count,
  output logic [7:0]  write_data,
  output logic [10:0] write_addr,
  output logic        write_strobe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ROWS_LOG2-1:0] LAST_ROW = '1;

  state_t                 state_reg, state_next;
  logic [6:0]             char_reg, char_next;
  logic [7:0]             fill_reg, fill_next;
  logic [ROWS_LOG2-1:0]   row_reg, row_next;
  logic [7:0]             count_reg;
  logic                   strobe_reg, strobe_next;
  logic [7:0]             wdata_reg, wdata_next;
  logic [10:0]            waddr_reg, waddr_next;
  logic                   win;

  // With the window disabled, writes are always permitted.
  assign win = window | (USE_WINDOW == 1'b0);

  // State, command latches, write-port registers and completion counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      char_reg   <= '0;
      fill_reg   <= '0;
      row_reg    <= '0;
      count_reg  <= '0;
      strobe_reg <= 1'b0;
      wdata_reg  <= '0;
      waddr_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      char_reg   <= char_next;
      fill_reg   <= fill_next;
      row_reg    <= row_next;
      strobe_reg <= strobe_next;
      wdata_reg  <= wdata_next;
      waddr_reg  <= waddr_next;
      if (state_reg == DONE) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  // Next-state logic, handshakes and the write that goes out next cycle.
  always_comb begin
    state_next  = state_reg;
    char_next   = char_reg;
    fill_next   = fill_reg;
    row_next    = row_reg;
    strobe_next = 1'b0;
    wdata_next  = wdata_reg;
    waddr_next  = waddr_reg;
    cmd_ready   = 1'b0;
    data_ready  = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          char_next = cmd_char;
          if (cmd_op) begin
            fill_next = cmd_fill;
          end
          row_next   = '0;
          state_next = cmd_op ? FILL : LOAD;
        end
      end

      LOAD: begin
        // Abort forces data_ready low so a final-row handshake cannot slip in.
        data_ready = win & ~abort;
        if (abort) begin
          state_next = IDLE;
        end else if (data_valid && win) begin
          strobe_next = 1'b1;
          waddr_next  = {char_reg, row_reg};
          wdata_next  = data;
          row_next    = row_reg + 1'b1;
          if (row_reg == LAST_ROW) begin
            state_next = DONE;
          end
        end
      end

      FILL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (win) begin
          strobe_next = 1'b1;
          waddr_next  = {char_reg, row_reg};
          wdata_next  = fill_reg;
          row_next    = row_reg + 1'b1;
          if (row_reg == LAST_ROW) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign glyph_count  = count_reg;
  assign write_strobe = strobe_reg;
  assign write_data   = wdata_reg;
  assign write_addr   = waddr_reg;

endmodule

// File: tb/tb_glyph_loader.sv
// Testbench for glyph_loader: expected RAM writes are queued when stimulus is
// driven and popped by a monitor as write strobes appear.
module tb_glyph_loader;

  logic        clk = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_valid_nw;
  logic        cmd_op;
  logic [6:0]  cmd_char;
  logic [7:0]  cmd_fill;
  logic        data_valid;
  logic [7:0]  data;
  logic        window;
  logic        abort;

  logic        cmd_ready, data_ready, busy, done, write_strobe;
  logic [7:0]  glyph_count, write_data;
  logic [10:0] write_addr;

  logic        cmd_ready_nw, data_ready_nw, busy_nw, done_nw, write_strobe_nw;
  logic [7:0]  glyph_count_nw, write_data_nw;
  logic [10:0] write_addr_nw;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_nw_q[$];
  wr_t mon_e, mon_nw_e;

  int check_cnt    = 0;
  int pass_cnt     = 0;
  int strobe_total = 0;
  int done_total   = 0;
  int exp_count    = 0;

  always #5 clk = ~clk;

  glyph_loader #(.USE_WINDOW(1'b1), .ROWS_LOG2(4)) u_dut (
    .CLK(clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_char(cmd_char), .cmd_fill(cmd_fill),
    .data_valid(data_valid), .data(data), .data_ready(data_ready),
    .window(window), .abort(abort), .busy(busy), .done(done),
    .glyph_count(glyph_count), .write_data(write_data),
    .write_addr(write_addr), .write_strobe(write_strobe)
  );

  glyph_loader #(.USE_WINDOW(1'b0), .ROWS_LOG2(4)) u_dut_nw (
    .CLK(clk), .RST(RST),
    .cmd_valid(cmd_valid_nw), .cmd_ready(cmd_ready_nw), .cmd_op(cmd_op),
    .cmd_char(cmd_char), .cmd_fill(cmd_fill),
    .data_valid(data_valid), .data(data), .data_ready(data_ready_nw),
    .window(window), .abort(abort), .busy(busy_nw), .done(done_nw),
    .glyph_count(glyph_count_nw), .write_data(write_data_nw),
    .write_addr(write_addr_nw), .write_strobe(write_strobe_nw)
  );

  // Scoreboard: every strobe must match the oldest queued expected write.
  always @(negedge clk) begin
    if (write_strobe) begin
      strobe_total++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe got addr=%h data=%h expected no write", write_addr, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (write_addr !== mon_e.addr || write_data !== mon_e.data)
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h", write_addr, write_data, mon_e.addr, mon_e.data);
        else begin
          pass_cnt++;
          $display("write addr=%h data=%h", write_addr, write_data);
        end
      end
    end
    if (done) done_total++;
    if (write_strobe_nw) begin
      check_cnt++;
      if (exp_nw_q.size() == 0) begin
        $display("FAIL unexpected_strobe_nw got addr=%h data=%h expected no write", write_addr_nw, write_data_nw);
      end else begin
        mon_nw_e = exp_nw_q.pop_front();
        if (write_addr_nw !== mon_nw_e.addr || write_data_nw !== mon_nw_e.data)
          $display("FAIL write_nw got addr=%h data=%h expected addr=%h data=%h", write_addr_nw, write_data_nw, mon_nw_e.addr, mon_nw_e.data);
        else begin
          pass_cnt++;
          $display("write_nw addr=%h data=%h", write_addr_nw, write_data_nw);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] ch, input int row, input logic [7:0] d);
    wr_t w;
    w.addr = {ch, 4'(row)};
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic issue_cmd(input logic op, input logic [6:0] ch, input logic [7:0] fb);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    cmd_fill  = fb;
    #1;
    check_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle got %b expected 1", cmd_ready);
    else pass_cnt++;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    check_cnt++;
    if ({write_strobe, write_addr, write_data} !== 20'h0) $display("FAIL reset_write_port got strobe=%b addr=%h data=%h expected 0/000/00", write_strobe, write_addr, write_data);
    else pass_cnt++;
    check_cnt++;
    if ({done, busy, data_ready, glyph_count} !== 11'h0) $display("FAIL reset_status got done=%b busy=%b data_ready=%b count=%0d expected all 0", done, busy, data_ready, glyph_count);
    else pass_cnt++;
    check_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready);
    else pass_cnt++;
    RST = 1'b0;
    tick();
    $display("test_reset complete");
  endtask

  task automatic test_load_basic();
    window = 1'b1;
    issue_cmd(1'b0, 7'h41, 8'h00);
    data_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'(i);
      push_exp(7'h41, i, 8'(i));
      #1;
      check_cnt++;
      if (data_ready !== 1'b1) $display("FAIL load_data_ready row=%0d got %b expected 1", i, data_ready);
      else pass_cnt++;
      check_cnt++;
      if (write_strobe !== (i > 0)) $display("FAIL load_consecutive row=%0d got %b expected %b", i, write_strobe, (i > 0));
      else pass_cnt++;
      tick();
    end
    data_valid = 1'b0;
    check_cnt++;
    if (done !== 1'b1 || write_strobe !== 1'b1) $display("FAIL load_done_with_last got done=%b strobe=%b expected 1/1", done, write_strobe);
    else pass_cnt++;
    exp_count++;
    tick();
    check_cnt++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || glyph_count !== 8'(exp_count))
      $display("FAIL load_after got cmd_ready=%b done=%b count=%0d expected 1/0/%0d", cmd_ready, done, glyph_count, exp_count);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL load_all_written got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
    $display("test_load_basic complete");
  endtask

  task automatic test_fill_window();
    int   cycles;
    logic prev_win;
    for (int i = 0; i < 16; i++) push_exp(7'h02, i, 8'hFF);
    issue_cmd(1'b1, 7'h02, 8'hFF);
    cycles = 0;
    while (!done && cycles < 100) begin
      window   = (cycles % 2 == 0);
      prev_win = window;
      tick();
      cycles++;
      check_cnt++;
      if (write_strobe !== prev_win) $display("FAIL fill_strobe_follows_window cycle=%0d got %b expected %b", cycles, write_strobe, prev_win);
      else pass_cnt++;
    end
    check_cnt++;
    if (cycles != 31) $display("FAIL fill_cycle_count got %0d expected 31", cycles);
    else pass_cnt++;
    window = 1'b1;
    exp_count++;
    tick();
    check_cnt++;
    if (glyph_count !== 8'(exp_count)) $display("FAIL fill_count got %0d expected %0d", glyph_count, exp_count);
    else pass_cnt++;
    $display("test_fill_window complete");
  endtask

  task automatic test_no_window();
    int   rows;
    int   c;
    logic v;
    wr_t  w;
    window       = 1'b0;
    cmd_valid_nw = 1'b1;
    cmd_op       = 1'b0;
    cmd_char     = 7'h7F;
    #1;
    check_cnt++;
    if (cmd_ready_nw !== 1'b1) $display("FAIL nw_cmd_ready got %b expected 1", cmd_ready_nw);
    else pass_cnt++;
    tick();
    cmd_valid_nw = 1'b0;
    rows = 0;
    c    = 0;
    while (rows < 16 && c < 100) begin
      v          = (c % 3 != 2);
      data_valid = v;
      data       = 8'(rows * 7 + 3);
      if (v) begin
        w.addr = {7'h7F, 4'(rows)};
        w.data = data;
        exp_nw_q.push_back(w);
      end
      #1;
      check_cnt++;
      if (data_ready_nw !== 1'b1) $display("FAIL nw_data_ready cycle=%0d got %b expected 1", c, data_ready_nw);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (write_strobe_nw !== v) $display("FAIL nw_strobe_gap cycle=%0d got %b expected %b", c, write_strobe_nw, v);
      else pass_cnt++;
      if (v) rows++;
      c++;
    end
    data_valid = 1'b0;
    check_cnt++;
    if (done_nw !== 1'b1) $display("FAIL nw_done got %b expected 1", done_nw);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (cmd_ready_nw !== 1'b1 || glyph_count_nw !== 8'd1 || exp_nw_q.size() != 0)
      $display("FAIL nw_after got cmd_ready=%b count=%0d pending=%0d expected 1/1/0", cmd_ready_nw, glyph_count_nw, exp_nw_q.size());
    else pass_cnt++;
    window = 1'b1;
    $display("test_no_window complete");
  endtask

  task automatic test_abort();
    int c;
    window = 1'b1;
    issue_cmd(1'b0, 7'h04, 8'h00);
    data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'h50 + 8'(i);
      push_exp(7'h04, i, data);
      tick();
    end
    abort = 1'b1;
    data  = 8'h55;
    #1;
    check_cnt++;
    if (data_ready !== 1'b0 || busy !== 1'b1) $display("FAIL abort_data_ready got ready=%b busy=%b expected 0/1", data_ready, busy);
    else pass_cnt++;
    tick();
    abort      = 1'b0;
    data_valid = 1'b0;
    check_cnt++;
    if (write_strobe !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || glyph_count !== 8'(exp_count))
      $display("FAIL abort_after got strobe=%b cmd_ready=%b done=%b count=%0d expected 0/1/0/%0d", write_strobe, cmd_ready, done, glyph_count, exp_count);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL abort_rows got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < 16; i++) push_exp(7'h10, i, 8'hA5);
    issue_cmd(1'b1, 7'h10, 8'hA5);
    c = 0;
    while (!done && c < 40) begin
      tick();
      c++;
    end
    check_cnt++;
    if (c != 16) $display("FAIL abort_next_fill got %0d cycles expected 16", c);
    else pass_cnt++;
    exp_count++;
    tick();
    check_cnt++;
    if (glyph_count !== 8'(exp_count)) $display("FAIL abort_next_count got %0d expected %0d", glyph_count, exp_count);
    else pass_cnt++;
    $display("test_abort complete");
  endtask

  task automatic test_reset_mid_fill();
    window = 1'b1;
    for (int i = 0; i < 7; i++) push_exp(7'h05, i, 8'h3C);
    issue_cmd(1'b1, 7'h05, 8'h3C);
    repeat (7) tick();
    check_cnt++;
    if (write_strobe !== 1'b1 || write_addr !== 11'h056) $display("FAIL midfill_row6 got strobe=%b addr=%h expected 1/056", write_strobe, write_addr);
    else pass_cnt++;
    RST = 1'b1;
    tick();
    check_cnt++;
    if ({write_strobe, write_addr, write_data, done, busy, glyph_count} !== 30'h0 || cmd_ready !== 1'b1)
      $display("FAIL midfill_reset got strobe=%b addr=%h data=%h done=%b busy=%b count=%0d cmd_ready=%b expected 0s and cmd_ready=1", write_strobe, write_addr, write_data, done, busy, glyph_count, cmd_ready);
    else pass_cnt++;
    RST       = 1'b0;
    exp_count = 0;
    repeat (5) tick();
    check_cnt++;
    if (write_strobe !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) $display("FAIL midfill_quiet got strobe=%b busy=%b pending=%0d expected 0/0/0", write_strobe, busy, exp_q.size());
    else pass_cnt++;
    $display("test_reset_mid_fill complete");
  endtask

  task automatic test_back_to_back();
    int s0;
    int d0;
    int w;
    window = 1'b1;
    s0 = strobe_total;
    d0 = done_total;
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cmd_char = 7'(i);
      cmd_fill = 8'(i) ^ 8'h5A;
      w = 0;
      while (!cmd_ready && w < 40) begin
        tick();
        w++;
      end
      if (w >= 40) begin
        check_cnt++;
        $display("FAIL b2b_timeout cmd=%0d got cmd_ready=0 expected 1 within 40 cycles", i);
        break;
      end
      for (int r = 0; r < 16; r++) push_exp(7'(i), r, 8'(i) ^ 8'h5A);
      tick();
    end
    cmd_valid = 1'b0;
    w = 0;
    while (!cmd_ready && w < 40) begin
      tick();
      w++;
    end
    exp_count = (exp_count + 256) % 256;
    check_cnt++;
    if (glyph_count !== 8'(exp_count)) $display("FAIL b2b_wrap got %0d expected %0d", glyph_count, exp_count);
    else pass_cnt++;
    check_cnt++;
    if (strobe_total - s0 != 4096) $display("FAIL b2b_strobes got %0d expected 4096", strobe_total - s0);
    else pass_cnt++;
    check_cnt++;
    if (done_total - d0 != 256 || exp_q.size() != 0) $display("FAIL b2b_done got %0d dones pending=%0d expected 256/0", done_total - d0, exp_q.size());
    else pass_cnt++;
    $display("test_back_to_back complete");
  endtask

  initial begin
    RST          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_valid_nw = 1'b0;
    cmd_op       = 1'b0;
    cmd_char     = '0;
    cmd_fill     = '0;
    data_valid   = 1'b0;
    data         = '0;
    window       = 1'b0;
    abort        = 1'b0;
    test_reset();
    test_load_basic();
    test_fill_window();
    test_no_window();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
